fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose: instruction-fetch PC sequencer. Drives the imem request and presents fetched PCs to the IF/ID register.
// Latency: an accepted fetch appears on pc_if/if_valid one cycle after imem_ready; a redirect takes effect on the next edge.
// Backpressure: imem_ready=0 holds the request at pc; stall=1 parks an accepted fetch in HOLD until ID releases it.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   stall                ID-stage hold request
//   branch_taken/target  one-cycle redirect with its target PC
//   imem_ready           instruction memory completes the current fetch
//   pc, npc              current fetch address and pc + INC (mod 2^32)
//   imem_req             fetch request, high exactly in REQ
//   if_valid, pc_if      fetched-instruction valid flag and its address
//   fetch_count          number of accepted fetches (wraps at 16 bits)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] INC      = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic        if_valid,
    output logic [31:0] pc_if,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    // 32-bit add naturally wraps at 2^32.
    assign npc      = pc + INC;
    assign imem_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_if       <= RESET_PC;
            if_valid    <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    // Redirects are ignored until the first request is issued.
                    if_valid <= 1'b0;
                    state    <= REQ;
                end
                REQ: begin
                    if (branch_taken) begin
                        // Redirect wins over a completing fetch, which is dropped.
                        pc       <= branch_target;
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end else if (imem_ready) begin
                        pc_if       <= pc;
                        if_valid    <= 1'b1;
                        fetch_count <= fetch_count + 16'd1;
                        if (stall) begin
                            // Keep pc so the parked instruction's successor is fetched on release.
                            state <= HOLD;
                        end else begin
                            pc <= npc;
                        end
                    end else begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc       <= branch_target;
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end else if (!stall) begin
                        // ID consumes the parked instruction on this edge.
                        pc       <= npc;
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                default: begin
                    if_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: self-checking bench for fetch_sequencer against a rule-level reference model.
// Latency: model is advanced at each rising edge and compared 1 time unit later.
// Backpressure: stall/imem_ready are driven directly, directed scenarios then random traffic.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] INC      = 32'h00000001;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic        if_valid;
    logic [31:0] pc_if;
    logic [15:0] fetch_count;

    fetch_sequencer #(.RESET_PC(RESET_PC), .INC(INC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .npc           (npc),
        .imem_req      (imem_req),
        .if_valid      (if_valid),
        .pc_if         (pc_if),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks whether the sequencer has started issuing and
    // whether an accepted instruction is parked waiting for ID.
    bit          m_started;
    bit          m_parked;
    logic [31:0] m_pc;
    logic [31:0] m_pc_if;
    bit          m_valid;
    int unsigned m_count;

    task automatic model_edge();
        if (rst) begin
            m_started = 0;
            m_parked  = 0;
            m_pc      = RESET_PC;
            m_pc_if   = RESET_PC;
            m_valid   = 0;
            m_count   = 0;
        end else if (!m_started) begin
            m_started = 1;
            m_valid   = 0;
        end else if (branch_taken) begin
            m_pc     = branch_target;
            m_valid  = 0;
            m_parked = 0;
        end else if (m_parked) begin
            if (!stall) begin
                m_pc     = m_pc + INC;
                m_valid  = 0;
                m_parked = 0;
            end
        end else if (imem_ready) begin
            m_pc_if = m_pc;
            m_valid = 1;
            m_count = (m_count + 1) % 65536;
            if (stall) m_parked = 1;
            else       m_pc = m_pc + INC;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("pc",          pc,                 m_pc);
        chk("npc",         npc,                m_pc + INC);
        chk("imem_req",    {31'd0, imem_req},  {31'd0, (m_started && !m_parked)});
        chk("if_valid",    {31'd0, if_valid},  {31'd0, m_valid});
        if (m_valid) chk("pc_if", pc_if, m_pc_if);
        chk("fetch_count", {16'd0, fetch_count}, m_count[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] t,
                         input logic rdy, input logic s);
        rst           = r;
        branch_taken  = b;
        branch_target = t;
        imem_ready    = rdy;
        stall         = s;
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b0;
        m_started = 0; m_parked = 0; m_pc = 0; m_pc_if = 0; m_valid = 0; m_count = 0;

        // Reset state, with ready asserted to show it is overridden.
        drive(1, 0, 32'h0, 1, 0);
        drive(1, 1, 32'h44, 1, 0);
        chk("rst_pc",   pc, 32'h0);
        chk("rst_npc",  npc, 32'h1);
        chk("rst_req",  {31'd0, imem_req}, 32'd0);
        chk("rst_vld",  {31'd0, if_valid}, 32'd0);

        // IDLE -> REQ; a branch in IDLE is ignored.
        drive(0, 1, 32'h55, 1, 0);
        chk("idle_br_pc", pc, 32'h0);
        chk("req_entry",  {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h0, 1, 0);
            chk("seq_pc_if", pc_if, i);
            chk("seq_vld",   {31'd0, if_valid}, 32'd1);
        end
        chk("seq_pc",    pc, 32'd4);
        chk("seq_count", {16'd0, fetch_count}, 32'd4);

        // Memory not ready at pc=5.
        drive(0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, $urandom_range(0, 1));
            chk("wait_pc",  pc, 32'd5);
            chk("wait_vld", {31'd0, if_valid}, 32'd0);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
        end
        drive(0, 0, 32'h0, 1, 0);
        chk("ready_pc_if", pc_if, 32'd5);
        chk("ready_pc",    pc, 32'd6);

        // Stall an accepted fetch at pc=8.
        drive(0, 0, 32'h0, 1, 0);
        drive(0, 0, 32'h0, 1, 0);
        drive(0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, $urandom_range(0, 1), 1);
            chk("hold_pc",    pc, 32'd8);
            chk("hold_pc_if", pc_if, 32'd8);
            chk("hold_vld",   {31'd0, if_valid}, 32'd1);
            chk("hold_req",   {31'd0, imem_req}, 32'd0);
        end
        drive(0, 0, 32'h0, 0, 0);
        chk("release_pc",  pc, 32'd9);
        chk("release_vld", {31'd0, if_valid}, 32'd0);
        chk("release_req", {31'd0, imem_req}, 32'd1);

        // Branch beats ready+stall.
        drive(0, 1, 32'h100, 1, 1);
        chk("br_pc",    pc, 32'h100);
        chk("br_vld",   {31'd0, if_valid}, 32'd0);
        chk("br_req",   {31'd0, imem_req}, 32'd1);
        chk("br_count", {16'd0, fetch_count}, 32'd9);

        // PC wrap.
        drive(0, 1, 32'hFFFFFFFF, 0, 0);
        drive(0, 0, 32'h0, 1, 0);
        chk("wrap_pc_if", pc_if, 32'hFFFFFFFF);
        chk("wrap_pc",    pc, 32'h0);
        chk("wrap_npc",   npc, 32'h1);

        // Reset while parked in HOLD.
        drive(0, 0, 32'h0, 1, 1);
        chk("pre_rst_vld", {31'd0, if_valid}, 32'd1);
        drive(1, 0, 32'h0, 1, 1);
        chk("hold_rst_pc",    pc, 32'h0);
        chk("hold_rst_vld",   {31'd0, if_valid}, 32'd0);
        chk("hold_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("hold_rst_count", {16'd0, fetch_count}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 2)) : $urandom;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), tgt,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end

        // fetch_count wrap at full throughput.
        drive(1, 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 65536; i++) drive(0, 0, 32'h0, 1, 0);
        chk("cnt_wrap",    {16'd0, fetch_count}, 32'd0);
        chk("cnt_wrap_pc", pc, 32'd65536);
        drive(0, 0, 32'h0, 1, 0);
        chk("cnt_after",   {16'd0, fetch_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
